// File: rtl/hram_wb_arbiter.sv
// Three-master Wishbone arbiter in front of the HyperRAM controller: round-robin
// grant with no preemption, combinational owner pass-through, watchdog abort.
module hram_wb_arbiter #(
    parameter int AW      = 32,
    parameter int TIMEOUT = 1023
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,

    input  logic [AW-1:0] m0_adr_i,
    input  logic [31:0]   m0_dat_i,
    output logic [31:0]   m0_dat_o,
    input  logic [3:0]    m0_sel_i,
    input  logic          m0_we_i,
    input  logic [2:0]    m0_cti_i,
    input  logic [1:0]    m0_bte_i,
    input  logic          m0_cyc_i,
    input  logic          m0_stb_i,
    output logic          m0_ack_o,
    output logic          m0_err_o,

    input  logic [AW-1:0] m1_adr_i,
    input  logic [31:0]   m1_dat_i,
    output logic [31:0]   m1_dat_o,
    input  logic [3:0]    m1_sel_i,
    input  logic          m1_we_i,
    input  logic [2:0]    m1_cti_i,
    input  logic [1:0]    m1_bte_i,
    input  logic          m1_cyc_i,
    input  logic          m1_stb_i,
    output logic          m1_ack_o,
    output logic          m1_err_o,

    input  logic [AW-1:0] m2_adr_i,
    input  logic [31:0]   m2_dat_i,
    output logic [31:0]   m2_dat_o,
    input  logic [3:0]    m2_sel_i,
    input  logic          m2_we_i,
    input  logic [2:0]    m2_cti_i,
    input  logic [1:0]    m2_bte_i,
    input  logic          m2_cyc_i,
    input  logic          m2_stb_i,
    output logic          m2_ack_o,
    output logic          m2_err_o,

    output logic [AW-1:0] s_adr_o,
    output logic [31:0]   s_dat_o,
    output logic [3:0]    s_sel_o,
    output logic          s_we_o,
    output logic [2:0]    s_cti_o,
    output logic [1:0]    s_bte_o,
    output logic          s_cyc_o,
    output logic          s_stb_o,
    input  logic [31:0]   s_dat_i,
    input  logic          s_ack_i,
    input  logic          s_err_i,

    output logic [2:0]    grant_o,
    output logic          timeout_o
);
    localparam int          NUM_M = 3;
    localparam logic [15:0] WD_LIM = 16'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, BUSY, ABORT} state_t;

    typedef struct packed {
        logic [AW-1:0] adr;
        logic [31:0]   dat;
        logic [3:0]    sel;
        logic          we;
        logic [2:0]    cti;
        logic [1:0]    bte;
        logic          cyc;
        logic          stb;
    } wb_req_t;

    typedef struct packed {
        logic [31:0] dat;
        logic        ack;
        logic        err;
    } wb_rsp_t;

    wb_req_t [NUM_M-1:0] req;
    wb_rsp_t [NUM_M-1:0] rsp;
    wb_req_t             own_req;
    logic [NUM_M-1:0]    cyc_vec;

    state_t      state;
    logic [1:0]  owner;
    logic [1:0]  last_owner;
    logic [15:0] wdog;
    logic [1:0]  rr_pick;
    logic        rr_hit;
    logic        slv_resp;

    assign req[0] = '{adr: m0_adr_i, dat: m0_dat_i, sel: m0_sel_i, we: m0_we_i,
                      cti: m0_cti_i, bte: m0_bte_i, cyc: m0_cyc_i, stb: m0_stb_i};
    assign req[1] = '{adr: m1_adr_i, dat: m1_dat_i, sel: m1_sel_i, we: m1_we_i,
                      cti: m1_cti_i, bte: m1_bte_i, cyc: m1_cyc_i, stb: m1_stb_i};
    assign req[2] = '{adr: m2_adr_i, dat: m2_dat_i, sel: m2_sel_i, we: m2_we_i,
                      cti: m2_cti_i, bte: m2_bte_i, cyc: m2_cyc_i, stb: m2_stb_i};

    assign cyc_vec  = {m2_cyc_i, m1_cyc_i, m0_cyc_i};
    assign own_req  = req[owner];
    assign slv_resp = s_ack_i | s_err_i;

    function automatic logic [1:0] rr_idx(input logic [1:0] base, input int step);
        int sum;
        sum = (int'(base) + step) % NUM_M;
        return sum[1:0];
    endfunction

    // Scan farthest-first so the nearest requester after last_owner wins.
    always_comb begin
        rr_pick = 2'd0;
        rr_hit  = 1'b0;
        for (int k = NUM_M; k >= 1; k--) begin
            if (cyc_vec[rr_idx(last_owner, k)]) begin
                rr_pick = rr_idx(last_owner, k);
                rr_hit  = 1'b1;
            end
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state      <= IDLE;
            owner      <= 2'd0;
            last_owner <= 2'd2;
            wdog       <= 16'd0;
            grant_o    <= 3'b000;
            timeout_o  <= 1'b0;
        end else begin
            timeout_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (rr_hit) begin
                        state   <= BUSY;
                        owner   <= rr_pick;
                        grant_o <= 3'b001 << rr_pick;
                        wdog    <= 16'd0;
                    end
                end
                BUSY: begin
                    // A response on the terminal cycle still beats the abort.
                    if (!own_req.cyc) begin
                        state      <= IDLE;
                        last_owner <= owner;
                        grant_o    <= 3'b000;
                    end else if (slv_resp) begin
                        wdog <= 16'd0;
                    end else if (wdog >= WD_LIM) begin
                        state     <= ABORT;
                        timeout_o <= 1'b1;
                    end else if (own_req.stb) begin
                        wdog <= wdog + 16'd1;
                    end
                end
                ABORT: begin
                    if (!own_req.cyc) begin
                        state      <= IDLE;
                        last_owner <= owner;
                        grant_o    <= 3'b000;
                        wdog       <= 16'd0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        s_adr_o = '0;
        s_dat_o = 32'd0;
        s_sel_o = 4'd0;
        s_we_o  = 1'b0;
        s_cti_o = 3'd0;
        s_bte_o = 2'd0;
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        if (state == BUSY) begin
            s_adr_o = own_req.adr;
            s_dat_o = own_req.dat;
            s_sel_o = own_req.sel;
            s_we_o  = own_req.we;
            s_cti_o = own_req.cti;
            s_bte_o = own_req.bte;
            s_cyc_o = own_req.cyc;
            s_stb_o = own_req.stb;
        end
    end

    // Return path: only the granted master sees data/ack/err; abort err lasts
    // exactly as long as the timeout pulse.
    for (genvar i = 0; i < NUM_M; i++) begin : g_rsp
        logic sel_busy;
        logic sel_abort;
        assign sel_busy  = (state == BUSY)  && grant_o[i];
        assign sel_abort = (state == ABORT) && grant_o[i];
        assign rsp[i] = '{dat: sel_busy ? s_dat_i : 32'd0,
                          ack: sel_busy & s_ack_i,
                          err: (sel_busy & s_err_i) | (sel_abort & timeout_o)};
    end

    assign m0_dat_o = rsp[0].dat;
    assign m0_ack_o = rsp[0].ack;
    assign m0_err_o = rsp[0].err;
    assign m1_dat_o = rsp[1].dat;
    assign m1_ack_o = rsp[1].ack;
    assign m1_err_o = rsp[1].err;
    assign m2_dat_o = rsp[2].dat;
    assign m2_ack_o = rsp[2].ack;
    assign m2_err_o = rsp[2].err;

endmodule
